// File: rtl/cypher_controller_if.sv
// cypher_controller_if: start/digit handshake, datapath status and strobes, panel results
interface cypher_controller_if;
    logic       start;
    logic       digit_valid;
    logic       stop;
    logic       comparison;
    logic       check;
    logic       wr_sum;
    logic       wr_counter;
    logic       sel_sum;
    logic       sel_counter;
    logic       read;
    logic       wr_comp;
    logic       busy;
    logic       unlocked;
    logic       alarm;
    logic [1:0] fail_count;

    modport master (
        output start, digit_valid, stop, comparison, check,
        input  wr_sum, wr_counter, sel_sum, sel_counter, read, wr_comp,
        input  busy, unlocked, alarm, fail_count
    );

    modport slave (
        input  start, digit_valid, stop, comparison, check,
        output wr_sum, wr_counter, sel_sum, sel_counter, read, wr_comp,
        output busy, unlocked, alarm, fail_count
    );
endinterface

// File: rtl/cypher_controller.sv
// cypher_controller: entry FSM driving the cypher datapath, with failed-attempt lockout
module cypher_controller #(
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 16
) (
    input logic                clock,
    input logic                reset,
    cypher_controller_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WAIT, EVAL, CHECK, PASS, FAIL, LOCK} state_t;

    state_t     state, state_next;
    logic [1:0] fail_count, fail_next;
    logic [7:0] timer, timer_next;
    logic       clear, accept, advance;
    logic       unused_check;

    assign unused_check = bus.check;

    // State, consecutive-failure count and lockout timer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            fail_count <= 2'd0;
            timer      <= 8'd0;
        end else begin
            state      <= state_next;
            fail_count <= fail_next;
            timer      <= timer_next;
        end
    end

    // Next state plus the clear/accept/advance actions that map onto datapath strobes
    always_comb begin
        state_next = state;
        fail_next  = fail_count;
        timer_next = timer;
        clear      = 1'b0;
        accept     = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                clear      = 1'b1;
                state_next = WAIT;
            end
            WAIT: if (bus.start) begin
                clear = 1'b1;
            end else if (bus.digit_valid) begin
                accept     = 1'b1;
                state_next = EVAL;
            end
            EVAL: if (bus.comparison) begin
                advance    = 1'b1;
                state_next = CHECK;
            end else begin
                state_next = FAIL;
            end
            CHECK: if (bus.stop) begin
                fail_next  = 2'd0;
                state_next = PASS;
            end else begin
                state_next = WAIT;
            end
            PASS: if (bus.start) begin
                clear      = 1'b1;
                state_next = WAIT;
            end
            FAIL: if (int'(fail_count) + 1 == MAX_FAILS) begin
                timer_next = 8'(LOCKOUT_CYCLES - 1);
                state_next = LOCK;
            end else begin
                fail_next  = fail_count + 2'd1;
                state_next = IDLE;
            end
            LOCK: if (timer == 8'd0) begin
                fail_next  = 2'd0;
                state_next = IDLE;
            end else begin
                timer_next = timer - 8'd1;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.wr_sum      = clear | advance;
    assign bus.wr_counter  = clear | advance;
    assign bus.sel_sum     = advance;
    assign bus.sel_counter = advance;
    assign bus.read        = accept;
    assign bus.wr_comp     = accept;
    assign bus.busy        = state inside {WAIT, EVAL, CHECK};
    assign bus.unlocked    = state == PASS;
    assign bus.alarm       = state == LOCK;
    assign bus.fail_count  = fail_count;
endmodule

// File: tb/tb_cypher_controller.sv
// tb_cypher_controller: directed checks of the cypher controller against a small datapath model
module tb_cypher_controller;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] seq = 4'h0;
    logic [3:0] dig = 4'h0;
    logic [7:0] sum = 8'd0;
    logic [2:0] cnt = 3'd0;
    logic       comp_q = 1'b0;
    logic [3:0] digits [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
    int         reads = 0;
    int         checks = 0;
    int         errors = 0;

    localparam logic [5:0] S_NONE   = 6'b000000;
    localparam logic [5:0] S_CLEAR  = 6'b110000;
    localparam logic [5:0] S_ACCEPT = 6'b000011;
    localparam logic [5:0] S_ADV    = 6'b111100;

    cypher_controller_if bus ();

    cypher_controller #(.MAX_FAILS(3), .LOCKOUT_CYCLES(16)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    // Datapath model: digit latch, comparison latch, sum and counter registers
    always @(posedge clock) begin
        if (bus.read) begin
            dig   <= seq;
            reads <= reads + 1;
        end
        if (bus.wr_comp) comp_q <= (cnt < 3'd4) && (seq == digits[cnt[1:0]]);
        if (bus.wr_sum) sum <= bus.sel_sum ? sum + 8'(dig) : 8'd0;
        if (bus.wr_counter) cnt <= bus.sel_counter ? cnt + 3'd1 : 3'd0;
    end

    assign bus.stop       = cnt >= 3'd4;
    assign bus.comparison = comp_q;
    assign bus.check      = !comp_q && cnt != 3'd0;

    function automatic logic [5:0] strobes();
        return {bus.wr_sum, bus.wr_counter, bus.sel_sum, bus.sel_counter, bus.read, bus.wr_comp};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic digit_ok(input logic [3:0] d);
        bus.digit_valid = 1'b1;
        seq = d;
        #1 chk("accept_strobes", 32'(strobes()), 32'(S_ACCEPT));
        step();
        bus.digit_valid = 1'b0;
        #1 chk("eval_strobes", 32'(strobes()), 32'(S_ADV));
        step();
        chk("check_busy", 32'(bus.busy), 1);
        step();
    endtask

    task automatic start_pulse();
        bus.start = 1'b1;
        #1 chk("clear_strobes", 32'(strobes()), 32'(S_CLEAR));
        step();
        bus.start = 1'b0;
    endtask

    task automatic full_entry();
        start_pulse();
        for (int i = 0; i < 4; i++) digit_ok(digits[i]);
        chk("unlocked", 32'(bus.unlocked), 1);
        chk("sum", 32'(sum), 10);
        chk("fail_count_pass", 32'(bus.fail_count), 0);
    endtask

    task automatic fail_entry();
        start_pulse();
        bus.digit_valid = 1'b1;
        seq = 4'h9;
        step();
        bus.digit_valid = 1'b0;
        #1 chk("mismatch_eval_strobes", 32'(strobes()), 32'(S_NONE));
        step();
        step();
    endtask

    initial begin
        int n;
        int r0;
        logic lock_strobes;
        bus.start = 1'b0;
        bus.digit_valid = 1'b0;
        step();
        chk("reset_outputs", 32'({bus.busy, bus.unlocked, bus.alarm, bus.fail_count}), 0);
        chk("reset_strobes", 32'(strobes()), 32'(S_NONE));
        step();
        reset = 1'b0;
        step();
        // Correct entry: unlocked exactly 13 cycles after start
        start_pulse();
        chk("wait_busy", 32'(bus.busy), 1);
        for (int i = 0; i < 4; i++) digit_ok(digits[i]);
        chk("unlocked_c13", 32'(bus.unlocked), 1);
        chk("busy_pass", 32'(bus.busy), 0);
        chk("sum_c13", 32'(sum), 10);
        chk("fc_c13", 32'(bus.fail_count), 0);
        // Wrong third digit
        start_pulse();
        chk("unlocked_dropped", 32'(bus.unlocked), 0);
        digit_ok(4'h1);
        digit_ok(4'h2);
        bus.digit_valid = 1'b1;
        seq = 4'h7;
        #1 chk("accept7", 32'(strobes()), 32'(S_ACCEPT));
        step();
        bus.digit_valid = 1'b0;
        #1 chk("eval7_strobes", 32'(strobes()), 32'(S_NONE));
        step();
        chk("fail_state_outs", 32'({bus.busy, bus.unlocked, bus.alarm}), 0);
        step();
        chk("fc_after_fail", 32'(bus.fail_count), 1);
        bus.digit_valid = 1'b1;
        seq = 4'h1;
        #1 chk("idle_no_read", 32'(strobes()), 32'(S_NONE));
        step();
        bus.digit_valid = 1'b0;
        chk("idle_stays", 32'(bus.busy), 0);
        full_entry();
        // Lockout after three failures
        fail_entry();
        chk("fc1", 32'(bus.fail_count), 1);
        fail_entry();
        chk("fc2", 32'(bus.fail_count), 2);
        fail_entry();
        n = 0;
        lock_strobes = 1'b0;
        while (bus.alarm && n < 100) begin
            bus.start = 1'b1;
            bus.digit_valid = 1'b1;
            #1 lock_strobes = lock_strobes | (|strobes());
            n++;
            step();
        end
        bus.start = 1'b0;
        bus.digit_valid = 1'b0;
        chk("alarm_cycles", n, 16);
        chk("lock_no_strobes", 32'(lock_strobes), 0);
        chk("fc_after_lock", 32'(bus.fail_count), 0);
        chk("idle_after_lock", 32'({bus.busy, bus.alarm}), 0);
        full_entry();
        // Restart mid-entry with a simultaneous digit
        start_pulse();
        digit_ok(4'h1);
        digit_ok(4'h2);
        bus.start = 1'b1;
        bus.digit_valid = 1'b1;
        seq = 4'h3;
        #1 chk("restart_clear_only", 32'(strobes()), 32'(S_CLEAR));
        step();
        bus.start = 1'b0;
        bus.digit_valid = 1'b0;
        chk("restart_busy", 32'(bus.busy), 1);
        for (int i = 0; i < 4; i++) digit_ok(digits[i]);
        chk("restart_unlocked", 32'(bus.unlocked), 1);
        chk("restart_sum", 32'(sum), 10);
        // Asynchronous reset during EVAL
        fail_entry();
        chk("fc_before_reset", 32'(bus.fail_count), 1);
        start_pulse();
        digit_ok(4'h1);
        bus.digit_valid = 1'b1;
        seq = 4'h2;
        step();
        bus.digit_valid = 1'b0;
        reset = 1'b1;
        #1 chk("async_reset_outs", 32'({bus.busy, bus.unlocked, bus.alarm, bus.fail_count}), 0);
        chk("async_reset_strobes", 32'(strobes()), 32'(S_NONE));
        step();
        reset = 1'b0;
        bus.digit_valid = 1'b1;
        seq = 4'h1;
        #1 chk("post_reset_no_read", 32'(strobes()), 32'(S_NONE));
        step();
        bus.digit_valid = 1'b0;
        full_entry();
        // digit_valid held high for the whole entry
        start_pulse();
        r0 = reads;
        bus.digit_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            seq = digits[i];
            #1 chk("held_accept", 32'(strobes()), 32'(S_ACCEPT));
            step();
            seq = 4'hf;
            step();
            step();
        end
        #1 chk("held_pass_no_read", 32'(strobes()), 32'(S_NONE));
        chk("held_reads", reads - r0, 4);
        chk("held_unlocked", 32'(bus.unlocked), 1);
        chk("held_sum", 32'(sum), 10);
        bus.digit_valid = 1'b0;
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
